// File: rtl/param_syncount.sv
// Modulo-N up/down counter with synchronous clear/load, Gray-coded view,
// combinational terminal count and a registered wrap pulse.
module param_syncount #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'(1) << WIDTH)) begin : g_bad_params
    $error("param_syncount: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Next count: clr beats load beats en; only a counting step can flag a wrap.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (32'(d) >= MODULUS) ? LAST : d;
    end else if (en) begin
      if (up) begin
        if (q == LAST) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          q_nxt    = LAST;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign q_gray = q ^ (q >> 1);
  assign tc     = en & (up ? (q == LAST) : (q == '0));

endmodule

// File: tb/tb_param_syncount.sv
// Scoreboard bench for param_syncount: MODULUS=10 and MODULUS=16 instances share
// stimulus; an arithmetic model queues expectations, a monitor pops and checks them.
module tb_param_syncount;

  logic       clk;
  logic       reset;
  logic       clr, load, en, up;
  logic [3:0] d;
  logic [3:0] q10, g10, q16, g16;
  logic       tc10, w10, tc16, w16;

  param_syncount #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q10), .q_gray(g10), .tc(tc10), .wrap(w10));

  param_syncount #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q16), .q_gray(g16), .tc(tc16), .wrap(w16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q10; bit w10; bit tc10;
    int q16; bit w16; bit tc16;
    bit cnt16; int pg16;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   mq10 = 0;
  int   mq16 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  // Behavioural rule for one edge of a modulo-m counter.
  task automatic model(input int m, inout int mq, input bit c, input bit l,
                       input int dv, input bit e, input bit u, output bit w);
    w = 1'b0;
    if (c) mq = 0;
    else if (l) mq = (dv >= m) ? m - 1 : dv;
    else if (e) begin
      if (u) begin w = (mq == m - 1); mq = (mq + 1) % m; end
      else   begin w = (mq == 0);     mq = (mq + m - 1) % m; end
    end
  endtask

  // Called at a falling edge: apply inputs, queue expectation for the next rising edge.
  task automatic step(input bit c, input bit l, input int dv, input bit e, input bit u);
    exp_t x;
    bit   w;
    clr = c; load = l; d = 4'(dv); en = e; up = u;
    x.pg16  = gray(mq16);
    x.cnt16 = !c && !l && e;
    model(10, mq10, c, l, dv, e, u, w);
    x.q10 = mq10; x.w10 = w; x.tc10 = e & (u ? (mq10 == 9) : (mq10 == 0));
    model(16, mq16, c, l, dv, e, u, w);
    x.q16 = mq16; x.w16 = w; x.tc16 = e & (u ? (mq16 == 15) : (mq16 == 0));
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Called at a falling edge: async reset between edges, held across one rising edge.
  task automatic reset_pulse(input bit e, input bit u);
    clr = 1'b0; load = 1'b0; en = e; up = u;
    reset = 1'b0;
    #1;
    chk("rst_q10", int'(q10), 0);
    chk("rst_w10", int'(w10), 0);
    chk("rst_g10", int'(g10), 0);
    chk("rst_tc10", int'(tc10), int'(e & ~u));
    chk("rst_q16", int'(q16), 0);
    chk("rst_w16", int'(w16), 0);
    chk("rst_tc16", int'(tc16), int'(e & ~u));
    @(negedge clk);
    chk("rst_hold_q10", int'(q10), 0);
    reset = 1'b1;
    mq10 = 0;
    mq16 = 0;
  endtask

  // Monitor: after each rising edge, compare DUT against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q10", int'(q10), x.q10);
        chk("wrap10", int'(w10), int'(x.w10));
        chk("tc10", int'(tc10), int'(x.tc10));
        chk("gray10", int'(g10), gray(x.q10));
        chk("q16", int'(q16), x.q16);
        chk("wrap16", int'(w16), int'(x.w16));
        chk("tc16", int'(tc16), int'(x.tc16));
        chk("gray16", int'(g16), gray(x.q16));
        if (x.cnt16) chk("gray16_onebit", $countones(4'(x.pg16) ^ g16), 1);
      end
    end
  end

  initial begin
    reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    #1;
    chk("por_q10", int'(q10), 0);
    chk("por_w10", int'(w10), 0);
    en = 1'b1;
    #1;
    chk("por_tc10_down", int'(tc10), 1);
    @(negedge clk);
    reset = 1'b1;

    // Up count through the wrap, then down count from reset.
    repeat (12) step(0, 0, 0, 1, 1);
    reset_pulse(1, 0);
    repeat (11) step(0, 0, 0, 1, 0);
    // Load saturation and control priority.
    step(0, 1, 7, 0, 1);
    step(0, 1, 13, 0, 1);
    step(1, 1, 5, 1, 1);
    step(0, 1, 9, 1, 1);
    step(0, 0, 0, 0, 1);
    // Direction flip around 5.
    step(0, 1, 5, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    // Async reset while q=8, restart counting from 0.
    step(0, 1, 8, 0, 1);
    reset_pulse(1, 1);
    step(0, 0, 0, 1, 1);
    // Full-range wrap on the MODULUS=16 instance, then a full Gray cycle both ways.
    step(0, 1, 15, 0, 1);
    step(0, 0, 0, 1, 1);
    reset_pulse(0, 1);
    repeat (17) step(0, 0, 0, 1, 1);
    repeat (17) step(0, 0, 0, 1, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse(1'($urandom), 1'($urandom));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom));
      chk("range10", int'(q10 < 4'd10), 1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_syncount.md
PARAM_SYNCOUNT -- requirements
Module: param_syncount

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter register width in bits (2..16).
REQ-002 SHALL provide parameter MODULUS, default 16, count sequence length; legal range 2..2**WIDTH.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port clr  input  1  synchronous clear to 0.
REQ-006 SHALL provide port load  input  1  synchronous parallel load of d.
REQ-007 SHALL provide port d  input  WIDTH  load value.
REQ-008 SHALL provide port en  input  1  count enable.
REQ-009 SHALL provide port up  input  1  direction; 1 = up, 0 = down.
REQ-010 SHALL provide port q  output  WIDTH  registered binary count.
REQ-011 SHALL provide port q_gray  output  WIDTH  Gray-coded count, combinational q ^ (q >> 1).
REQ-012 SHALL provide port tc  output  1  combinational terminal count: en & (up ? q == MODULUS-1 : q == 0).
REQ-013 SHALL provide port wrap  output  1  registered one-cycle pulse following a wrap transition.

Function
REQ-014 SHALL update q only on the rising edge of clk while reset is high.
REQ-015 SHALL apply control priority clr > load > en; lower-priority inputs are ignored in a cycle where a higher one is asserted.
REQ-016 SHALL set q to 0 on clr.
REQ-017 SHALL set q to d on load when d < MODULUS; SHALL set q to MODULUS-1 when d >= MODULUS (saturating load).
REQ-018 SHALL, with en=1 and up=1, advance q by 1; from MODULUS-1, the next value SHALL be 0.
REQ-019 SHALL, with en=1 and up=0, decrement q by 1; from 0, the next value SHALL be MODULUS-1.
REQ-020 SHALL hold q when clr=0, load=0 and en=0.
REQ-021 SHALL sample up on the same edge as the count; a direction change takes effect on that edge, with no extra cycle.
REQ-022 SHALL assert wrap for exactly the one cycle after an edge on which a count (not clr/load) moved q from MODULUS-1 to 0 (up) or from 0 to MODULUS-1 (down); wrap SHALL be 0 in all other cycles.
REQ-023 SHALL not assert wrap for clr or load, even when they produce the same q values as a wrap.
REQ-024 SHALL, when MODULUS = 2**WIDTH, behave as a free-running binary counter with natural overflow and underflow.
REQ-025 SHALL keep q within 0..MODULUS-1 at all times after reset, regardless of input sequence.
REQ-026 SHALL keep q_gray consistent with q every cycle; successive q_gray values SHALL differ by exactly one bit except across a wrap when MODULUS is not a power of two.

Reset
REQ-027 SHALL, while reset=0, force q=0 and wrap=0 immediately, independent of clk; hence q_gray=0.
REQ-028 SHALL, when reset asserts mid-count, abandon the count; the first active edge after reset deasserts SHALL operate from q=0.
REQ-029 SHALL keep tc combinational; during reset, tc = en & ~up.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-030 Up count: en=1, up=1 from reset for 12 edges -> q = 1..9, 0, 1, 2. wrap is high only in the cycle where q=0 after 9. tc is high while q=9.
REQ-031 Down count: reset, en=1, up=0 -> q = 9, 8, ... 0, 9. wrap is high in the cycle where q first becomes 9 and when it returns to 9. tc is high while q=0.
REQ-032 Load/priority: load=1 with d=7 -> q=7. load=1 with d=13 -> q=9. clr=1, load=1, en=1 together -> q=0, wrap=0.
REQ-033 Direction flip: q=5, en=1, up toggles every edge -> q = 6, 5, 6, 5. wrap stays 0.
REQ-034 Async reset: assert reset between edges while q=8 -> q=0 and wrap=0 before the next edge. Release reset with en=1 -> q=1 on the first edge.
REQ-035 Full-range mode, MODULUS=16: up count from 15 -> 0 with a wrap pulse. q_gray sequence from 0..15 is 0, 1, 3, 2, 6, ... 8, with single-bit changes throughout.
